// File: rtl/ethernet_rx.sv
// ethernet_rx: receive-side UDP engine. Parses and filters the Ethernet/IPv4/UDP
// header of frames from the CMAC RX stream, resolves the sender to a connection ID
// via the connection manager, and emits the payload realigned to byte 0 with the
// connection ID on tuser.
module ethernet_rx #(
  parameter int DATA_WIDTH     = 512,
  parameter int MAC_ADDR_WIDTH = 48,
  parameter int IP_ADDR_WIDTH  = 32,
  parameter int UDP_PORT_WIDTH = 16,
  parameter int HASH_WIDTH     = 8,
  parameter int CONN_ID_WIDTH  = HASH_WIDTH + $clog2(4)
) (
  input  logic                      rx_axis_aclk,
  input  logic                      rx_axis_rst,
  input  logic                      rx_engine_enable,
  input  logic [MAC_ADDR_WIDTH-1:0] my_config_src_macAddr,
  input  logic [IP_ADDR_WIDTH-1:0]  my_config_src_ipAddr,
  input  logic [UDP_PORT_WIDTH-1:0] my_config_src_udpPort,
  // raw frames from the CMAC
  input  logic                      cmac_rx_axis_tvalid,
  input  logic                      cmac_rx_axis_tlast,
  input  logic [DATA_WIDTH-1:0]     cmac_rx_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   cmac_rx_axis_tkeep,
  output logic                      cmac_rx_axis_tready,
  // forward-lookup request to the connection manager
  output logic                      m00_axis_fw_lookup_valid,
  output logic [IP_ADDR_WIDTH-1:0]  m00_axis_fw_lookup_ipAddr,
  output logic [UDP_PORT_WIDTH-1:0] m00_axis_fw_lookup_udpPort,
  input  logic                      m00_axis_fw_lookup_ready,
  // forward-lookup response
  input  logic                      s00_axis_fw_lookup_valid,
  input  logic                      s00_axis_fw_lookup_hit,
  input  logic [CONN_ID_WIDTH-1:0]  s00_axis_fw_lookup_connectionId,
  output logic                      s00_axis_fw_lookup_ready,
  // realigned UDP payload
  output logic                      udp_rx_axis_tvalid,
  output logic                      udp_rx_axis_tlast,
  output logic [DATA_WIDTH-1:0]     udp_rx_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   udp_rx_axis_tkeep,
  output logic [CONN_ID_WIDTH-1:0]  udp_rx_axis_tuser,
  input  logic                      udp_rx_axis_tready,
  // statistics
  output logic [31:0]               rx_pkt_count,
  output logic [31:0]               rx_drop_count
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int HDR_BYTES  = 42;                      // 14 Eth + 20 IPv4 + 8 UDP
  localparam int TAIL_BYTES = KEEP_WIDTH - HDR_BYTES;  // payload bytes in the first beat
  localparam int HDR_BITS   = HDR_BYTES * 8;
  localparam int TAIL_BITS  = TAIL_BYTES * 8;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP_REQ,
    LOOKUP_WAIT,
    STREAM,
    FLUSH,
    DROP
  } state_t;

  state_t state_reg, state_next;

  // Byte n of a beat lives at tdata[8n+7:8n]; header fields are big-endian.
  function automatic logic [7:0] byte_at(input logic [DATA_WIDTH-1:0] d, input int n);
    return d[8*n +: 8];
  endfunction

  // Header fields of the incoming beat (only meaningful on a frame's first beat)
  logic [47:0] in_dst_mac;
  logic [15:0] in_ethertype;
  logic [7:0]  in_ver_ihl;
  logic [7:0]  in_proto;
  logic [31:0] in_src_ip;
  logic [31:0] in_dst_ip;
  logic [15:0] in_src_port;
  logic [15:0] in_dst_port;
  logic        hdr_ok;

  assign in_dst_mac   = {byte_at(cmac_rx_axis_tdata, 0), byte_at(cmac_rx_axis_tdata, 1),
                         byte_at(cmac_rx_axis_tdata, 2), byte_at(cmac_rx_axis_tdata, 3),
                         byte_at(cmac_rx_axis_tdata, 4), byte_at(cmac_rx_axis_tdata, 5)};
  assign in_ethertype = {byte_at(cmac_rx_axis_tdata, 12), byte_at(cmac_rx_axis_tdata, 13)};
  assign in_ver_ihl   = byte_at(cmac_rx_axis_tdata, 14);
  assign in_proto     = byte_at(cmac_rx_axis_tdata, 23);
  assign in_src_ip    = {byte_at(cmac_rx_axis_tdata, 26), byte_at(cmac_rx_axis_tdata, 27),
                         byte_at(cmac_rx_axis_tdata, 28), byte_at(cmac_rx_axis_tdata, 29)};
  assign in_dst_ip    = {byte_at(cmac_rx_axis_tdata, 30), byte_at(cmac_rx_axis_tdata, 31),
                         byte_at(cmac_rx_axis_tdata, 32), byte_at(cmac_rx_axis_tdata, 33)};
  assign in_src_port  = {byte_at(cmac_rx_axis_tdata, 34), byte_at(cmac_rx_axis_tdata, 35)};
  assign in_dst_port  = {byte_at(cmac_rx_axis_tdata, 36), byte_at(cmac_rx_axis_tdata, 37)};

  // A frame is ours only if the whole header is present and every filter matches.
  assign hdr_ok = rx_engine_enable
               && cmac_rx_axis_tkeep[HDR_BYTES-1]
               && (in_dst_mac   == my_config_src_macAddr)
               && (in_ethertype == 16'h0800)
               && (in_ver_ihl   == 8'h45)
               && (in_proto     == 8'h11)
               && (in_dst_ip    == my_config_src_ipAddr)
               && (in_dst_port  == my_config_src_udpPort);

  // Holding registers: upper bytes of the previous beat and the lookup key
  logic [TAIL_BITS-1:0]      hold_data_reg;
  logic [TAIL_BYTES-1:0]     hold_keep_reg;
  logic                      first_last_reg;
  logic [IP_ADDR_WIDTH-1:0]  lookup_ip_reg;
  logic [UDP_PORT_WIDTH-1:0] lookup_port_reg;
  logic [CONN_ID_WIDTH-1:0]  conn_id_reg;

  // Output register
  logic                      out_valid_reg;
  logic                      out_last_reg;
  logic [DATA_WIDTH-1:0]     out_data_reg;
  logic [KEEP_WIDTH-1:0]     out_keep_reg;
  logic [CONN_ID_WIDTH-1:0]  out_user_reg;

  logic [31:0] pkt_count_reg;
  logic [31:0] drop_count_reg;

  // Control strobes from the FSM
  logic out_free;
  logic cmac_ready;
  logic lookup_valid;
  logic resp_ready;
  logic first_load;
  logic stream_load;
  logic stream_last;
  logic flush_load;
  logic conn_load;
  logic pkt_inc;
  logic drop_inc;

  assign out_free = !out_valid_reg || udp_rx_axis_tready;

  // State register
  always_ff @(posedge rx_axis_aclk) begin
    if (rx_axis_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake decode; everything idles while reset is held
  always_comb begin
    state_next   = state_reg;
    cmac_ready   = 1'b0;
    lookup_valid = 1'b0;
    resp_ready   = 1'b0;
    first_load   = 1'b0;
    stream_load  = 1'b0;
    stream_last  = 1'b0;
    flush_load   = 1'b0;
    conn_load    = 1'b0;
    pkt_inc      = 1'b0;
    drop_inc     = 1'b0;
    if (!rx_axis_rst) begin
      case (state_reg)
        IDLE: begin
          cmac_ready = 1'b1;
          if (cmac_rx_axis_tvalid) begin
            first_load = 1'b1;
            if (hdr_ok) begin
              state_next = LOOKUP_REQ;
            end else if (cmac_rx_axis_tlast) begin
              drop_inc = 1'b1;
            end else begin
              state_next = DROP;
            end
          end
        end
        LOOKUP_REQ: begin
          lookup_valid = 1'b1;
          if (m00_axis_fw_lookup_ready) begin
            state_next = LOOKUP_WAIT;
          end
        end
        LOOKUP_WAIT: begin
          resp_ready = 1'b1;
          if (s00_axis_fw_lookup_valid) begin
            if (s00_axis_fw_lookup_hit) begin
              conn_load  = 1'b1;
              state_next = first_last_reg ? FLUSH : STREAM;
            end else if (first_last_reg) begin
              drop_inc   = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = DROP;
            end
          end
        end
        STREAM: begin
          cmac_ready = out_free;
          if (cmac_rx_axis_tvalid && out_free) begin
            stream_load = 1'b1;
            if (cmac_rx_axis_tlast) begin
              // If the last beat has no bytes beyond the realignment point, it closes the packet.
              if (!cmac_rx_axis_tkeep[HDR_BYTES]) begin
                stream_last = 1'b1;
                pkt_inc     = 1'b1;
                state_next  = IDLE;
              end else begin
                state_next = FLUSH;
              end
            end
          end
        end
        FLUSH: begin
          if (!hold_keep_reg[0]) begin
            // Header-only frame: nothing to emit
            pkt_inc    = 1'b1;
            state_next = IDLE;
          end else if (out_free) begin
            flush_load = 1'b1;
            pkt_inc    = 1'b1;
            state_next = IDLE;
          end
        end
        DROP: begin
          cmac_ready = 1'b1;
          if (cmac_rx_axis_tvalid && cmac_rx_axis_tlast) begin
            drop_inc   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Capture the tail of each accepted beat, the lookup key and the connection ID
  always_ff @(posedge rx_axis_aclk) begin
    if (rx_axis_rst) begin
      hold_data_reg   <= '0;
      hold_keep_reg   <= '0;
      first_last_reg  <= 1'b0;
      lookup_ip_reg   <= '0;
      lookup_port_reg <= '0;
      conn_id_reg     <= '0;
    end else begin
      if (first_load || stream_load) begin
        hold_data_reg <= cmac_rx_axis_tdata[DATA_WIDTH-1:HDR_BITS];
        hold_keep_reg <= cmac_rx_axis_tkeep[KEEP_WIDTH-1:HDR_BYTES];
      end
      if (first_load) begin
        first_last_reg  <= cmac_rx_axis_tlast;
        lookup_ip_reg   <= in_src_ip;
        lookup_port_reg <= in_src_port;
      end
      if (conn_load) begin
        conn_id_reg <= s00_axis_fw_lookup_connectionId;
      end
    end
  end

  // Output register: loads a realigned beat, otherwise holds until consumed
  always_ff @(posedge rx_axis_aclk) begin
    if (rx_axis_rst) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      out_keep_reg  <= '0;
      out_user_reg  <= '0;
    end else if (stream_load) begin
      out_valid_reg <= 1'b1;
      out_last_reg  <= stream_last;
      out_data_reg  <= {cmac_rx_axis_tdata[HDR_BITS-1:0], hold_data_reg};
      out_keep_reg  <= {cmac_rx_axis_tkeep[HDR_BYTES-1:0], hold_keep_reg};
      out_user_reg  <= conn_id_reg;
    end else if (flush_load) begin
      out_valid_reg <= 1'b1;
      out_last_reg  <= 1'b1;
      out_data_reg  <= {{HDR_BITS{1'b0}}, hold_data_reg};
      out_keep_reg  <= {{HDR_BYTES{1'b0}}, hold_keep_reg};
      out_user_reg  <= conn_id_reg;
    end else if (udp_rx_axis_tready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Delivered / dropped frame counters, free-running with natural wrap
  always_ff @(posedge rx_axis_aclk) begin
    if (rx_axis_rst) begin
      pkt_count_reg  <= '0;
      drop_count_reg <= '0;
    end else begin
      if (pkt_inc) begin
        pkt_count_reg <= pkt_count_reg + 32'd1;
      end
      if (drop_inc) begin
        drop_count_reg <= drop_count_reg + 32'd1;
      end
    end
  end

  assign cmac_rx_axis_tready        = cmac_ready;
  assign m00_axis_fw_lookup_valid   = lookup_valid;
  assign m00_axis_fw_lookup_ipAddr  = lookup_ip_reg;
  assign m00_axis_fw_lookup_udpPort = lookup_port_reg;
  assign s00_axis_fw_lookup_ready   = resp_ready;
  assign udp_rx_axis_tvalid         = out_valid_reg;
  assign udp_rx_axis_tlast          = out_last_reg;
  assign udp_rx_axis_tdata          = out_data_reg;
  assign udp_rx_axis_tkeep          = out_keep_reg;
  assign udp_rx_axis_tuser          = out_user_reg;
  assign rx_pkt_count               = pkt_count_reg;
  assign rx_drop_count              = drop_count_reg;

endmodule

// File: tb/tb_ethernet_rx.sv
// tb_ethernet_rx: scoreboard bench for ethernet_rx. Frames are built as byte
// queues; expected payload beats and lookups are queued when a frame is built and
// checked as the DUT produces them.
`timescale 1ns/1ps
module tb_ethernet_rx;
  localparam int CW = 10;
  localparam logic [47:0] MY_MAC    = 48'h02_00_00_00_00_01;
  localparam logic [31:0] MY_IP     = 32'hC0A8_0001;
  localparam logic [15:0] MY_PORT   = 16'h1234;
  localparam logic [31:0] PEER_IP   = 32'h0A00_0002;
  localparam logic [15:0] PEER_PORT = 16'h5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          enable;
  logic          cmac_tvalid, cmac_tlast, cmac_tready;
  logic [511:0]  cmac_tdata;
  logic [63:0]   cmac_tkeep;
  logic          m00_valid, m00_ready;
  logic [31:0]   m00_ip;
  logic [15:0]   m00_port;
  logic          s00_valid, s00_hit, s00_ready;
  logic [CW-1:0] s00_id;
  logic          udp_tvalid, udp_tlast, udp_tready;
  logic [511:0]  udp_tdata;
  logic [63:0]   udp_tkeep;
  logic [CW-1:0] udp_tuser;
  logic [31:0]   pkt_count, drop_count;

  ethernet_rx dut (
    .rx_axis_aclk(clk), .rx_axis_rst(rst), .rx_engine_enable(enable),
    .my_config_src_macAddr(MY_MAC), .my_config_src_ipAddr(MY_IP),
    .my_config_src_udpPort(MY_PORT),
    .cmac_rx_axis_tvalid(cmac_tvalid), .cmac_rx_axis_tlast(cmac_tlast),
    .cmac_rx_axis_tdata(cmac_tdata), .cmac_rx_axis_tkeep(cmac_tkeep),
    .cmac_rx_axis_tready(cmac_tready),
    .m00_axis_fw_lookup_valid(m00_valid), .m00_axis_fw_lookup_ipAddr(m00_ip),
    .m00_axis_fw_lookup_udpPort(m00_port), .m00_axis_fw_lookup_ready(m00_ready),
    .s00_axis_fw_lookup_valid(s00_valid), .s00_axis_fw_lookup_hit(s00_hit),
    .s00_axis_fw_lookup_connectionId(s00_id), .s00_axis_fw_lookup_ready(s00_ready),
    .udp_rx_axis_tvalid(udp_tvalid), .udp_rx_axis_tlast(udp_tlast),
    .udp_rx_axis_tdata(udp_tdata), .udp_rx_axis_tkeep(udp_tkeep),
    .udp_rx_axis_tuser(udp_tuser), .udp_rx_axis_tready(udp_tready),
    .rx_pkt_count(pkt_count), .rx_drop_count(drop_count)
  );

  typedef struct {
    logic [511:0]  data;
    logic [63:0]   keep;
    logic          last;
    logic [CW-1:0] user;
  } beat_t;

  typedef struct {
    logic          hit;
    logic [CW-1:0] id;
  } rsp_t;

  beat_t      exp_q[$];
  rsp_t       lk_q[$];
  logic [7:0] frm[$];

  int n_checks = 0;
  int n_pass = 0;
  int n_lookups = 0;
  int exp_pkt = 0;
  int exp_drop = 0;
  bit bp_mode = 1'b0;
  bit rsp_fire = 1'b0;

  // Push n big-endian bytes of v onto the frame
  task automatic push_be(input logic [47:0] v, input int n);
    for (int i = 0; i < n; i++) frm.push_back(v[8*(n-1-i) +: 8]);
  endtask

  // Build an Ethernet/IPv4/UDP frame with plen random payload bytes
  task automatic build_frame(input logic [15:0] dport, input int plen);
    frm.delete();
    push_be(MY_MAC, 6);
    push_be(48'h02_11_22_33_44_55, 6);
    push_be(48'h0800, 2);
    push_be(48'h45, 1);
    push_be(48'h00, 1);
    push_be(48'(28 + plen), 2);
    push_be(48'h0000_4000, 4);
    push_be(48'h40, 1);
    push_be(48'h11, 1);
    push_be(48'h0, 2);
    push_be(48'(PEER_IP), 4);
    push_be(48'(MY_IP), 4);
    push_be(48'(PEER_PORT), 2);
    push_be(48'(dport), 2);
    push_be(48'(8 + plen), 2);
    push_be(48'h0, 2);
    for (int i = 0; i < plen; i++) frm.push_back(8'($urandom_range(0, 255)));
  endtask

  // Queue the lookup response and the payload beats this frame should produce
  task automatic expect_frame(input logic hit, input logic [CW-1:0] id);
    rsp_t r;
    int plen;
    r.hit = hit;
    r.id  = id;
    lk_q.push_back(r);
    if (!hit) return;
    plen = frm.size() - 42;
    for (int off = 0; off < plen; off += 64) begin
      beat_t b;
      b.data = '0;
      b.keep = '0;
      for (int j = 0; j < 64; j++) begin
        if (off + j < plen) begin
          b.data[8*j +: 8] = frm[42 + off + j];
          b.keep[j] = 1'b1;
        end
      end
      b.last = (off + 64 >= plen);
      b.user = id;
      exp_q.push_back(b);
    end
  endtask

  // Present beat b of the current frame and wait until the DUT takes it
  task automatic send_beat(input int b, inout int stalls);
    int nb;
    bit ok;
    nb = (frm.size() + 63) / 64;
    @(posedge clk); #1;
    cmac_tvalid = 1'b1;
    cmac_tdata  = '0;
    cmac_tkeep  = '0;
    for (int j = 0; j < 64; j++) begin
      if (b * 64 + j < frm.size()) begin
        cmac_tdata[8*j +: 8] = frm[b * 64 + j];
        cmac_tkeep[j] = 1'b1;
      end
    end
    cmac_tlast = (b == nb - 1);
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (cmac_tready) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL beat_accept: beat %0d not accepted within 1000 cycles (tready=%0b, required 1)", b, cmac_tready);
    end
  endtask

  task automatic send_frame(output int stalls);
    stalls = 0;
    for (int b = 0; b < (frm.size() + 63) / 64; b++) send_beat(b, stalls);
    @(posedge clk); #1;
    cmac_tvalid = 1'b0;
    cmac_tlast  = 1'b0;
  endtask

  // Wait (bounded) until every queued expectation has been consumed
  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && lk_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!done) $display("FAIL %s_drain: %0d beats / %0d lookups still pending, required 0", name, exp_q.size(), lk_q.size());
    else n_pass++;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_counts(input string name);
    n_checks++;
    if (pkt_count !== 32'(exp_pkt) || drop_count !== 32'(exp_drop)) begin
      $display("FAIL %s_counts: pkt=%0d drop=%0d, required pkt=%0d drop=%0d", name, pkt_count, drop_count, exp_pkt, exp_drop);
    end else begin
      n_pass++;
      $display("counts %s: pkt=%0d drop=%0d", name, pkt_count, drop_count);
    end
  endtask

  // Downstream ready: steady or toggling every cycle, changed just after the edge
  initial begin
    udp_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      udp_tready = bp_mode ? ~udp_tready : 1'b1;
    end
  end

  // Output monitor: every accepted payload beat is compared with the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && udp_tvalid && udp_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: keep=%h last=%0b user=%h, required no beat", udp_tkeep, udp_tlast, udp_tuser);
        end else begin
          beat_t e;
          logic [511:0] mask;
          e = exp_q.pop_front();
          mask = '0;
          for (int j = 0; j < 64; j++) if (e.keep[j]) mask[8*j +: 8] = 8'hFF;
          n_checks++;
          if ((udp_tdata & mask) !== e.data || udp_tkeep !== e.keep || udp_tlast !== e.last || udp_tuser !== e.user) begin
            $display("FAIL out_beat: got keep=%h last=%0b user=%h data=%h, required keep=%h last=%0b user=%h data=%h",
                     udp_tkeep, udp_tlast, udp_tuser, udp_tdata & mask, e.keep, e.last, e.user, e.data);
          end else begin
            n_pass++;
            $display("out beat keep=%h last=%0b user=%h", udp_tkeep, udp_tlast, udp_tuser);
          end
        end
      end
    end
  end

  // Connection-manager model: checks each request, answers with the queued response
  initial begin
    s00_valid = 1'b0;
    s00_hit   = 1'b0;
    s00_id    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        s00_valid = 1'b0;
        rsp_fire  = 1'b0;
      end else begin
        if (rsp_fire) begin
          s00_valid = 1'b0;
          rsp_fire  = 1'b0;
        end
        if (s00_valid && s00_ready) rsp_fire = 1'b1;
        if (m00_valid && m00_ready) begin
          n_lookups++;
          n_checks++;
          if (lk_q.size() == 0) begin
            $display("FAIL unexpected_lookup: ip=%h port=%h, required no request", m00_ip, m00_port);
          end else begin
            rsp_t r;
            r = lk_q.pop_front();
            if (m00_ip !== PEER_IP || m00_port !== PEER_PORT) begin
              $display("FAIL lookup_key: ip=%h port=%h, required ip=%h port=%h", m00_ip, m00_port, PEER_IP, PEER_PORT);
            end else begin
              n_pass++;
              $display("lookup ip=%h port=%h -> hit=%0b id=%h", m00_ip, m00_port, r.hit, r.id);
            end
            s00_valid = 1'b1;
            s00_hit   = r.hit;
            s00_id    = r.id;
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (cmac_tready !== 1'b0 || udp_tvalid !== 1'b0 || m00_valid !== 1'b0 || s00_ready !== 1'b0 ||
        udp_tuser !== '0 || pkt_count !== 32'd0 || drop_count !== 32'd0) begin
      $display("FAIL reset_state: tready=%0b tvalid=%0b lkv=%0b s00r=%0b tuser=%h pkt=%0d drop=%0d, required all 0",
               cmac_tready, udp_tvalid, m00_valid, s00_ready, udp_tuser, pkt_count, drop_count);
    end else begin
      n_pass++;
      $display("reset state ok");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmac_tready !== 1'b1) $display("FAIL reset_release_tready: tready=%0b, required 1", cmac_tready);
    else n_pass++;
  endtask

  // 106-byte frame: one full payload beat carrying tlast
  task automatic test_full_beat();
    int st;
    build_frame(MY_PORT, 64);
    expect_frame(1'b1, 10'h5);
    send_frame(st);
    exp_pkt++;
    wait_drain("full_beat");
    check_counts("full_beat");
  endtask

  // 100-byte frame: one partial payload beat of 58 bytes
  task automatic test_partial_beat();
    int st;
    build_frame(MY_PORT, 58);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL partial_setup: scoreboard not empty (%0d), required 0", exp_q.size());
    else n_pass++;
    expect_frame(1'b1, 10'h5);
    n_checks++;
    if (exp_q[0].keep !== 64'h03FF_FFFF_FFFF_FFFF) $display("FAIL partial_keep_model: %h, required 03ffffffffffffff", exp_q[0].keep);
    else n_pass++;
    send_frame(st);
    exp_pkt++;
    wait_drain("partial_beat");
    check_counts("partial_beat");
  endtask

  // Destination-port mismatch: no lookup, no output, never back-pressured
  task automatic test_port_mismatch();
    int st, lk0;
    lk0 = n_lookups;
    build_frame(16'h1235, 150);
    send_frame(st);
    exp_drop++;
    wait_drain("port_mismatch");
    n_checks++;
    if (st != 0 || n_lookups != lk0) $display("FAIL port_mismatch: stalls=%0d lookups=%0d, required stalls=0 lookups=%0d", st, n_lookups, lk0);
    else n_pass++;
    check_counts("port_mismatch");
  endtask

  // Other header filters, enable low, and a truncated header
  task automatic test_filters();
    int st, lk0;
    int bad_idx[5] = '{0, 12, 14, 23, 31};
    for (int k = 0; k < 7; k++) begin
      lk0 = n_lookups;
      build_frame(MY_PORT, 20);
      if (k < 5) frm[bad_idx[k]] = frm[bad_idx[k]] ^ 8'h01;
      if (k == 5) enable = 1'b0;
      if (k == 6) while (frm.size() > 30) void'(frm.pop_back());
      send_frame(st);
      enable = 1'b1;
      exp_drop++;
      wait_drain("filter");
      n_checks++;
      if (n_lookups != lk0 || drop_count !== 32'(exp_drop))
        $display("FAIL filter_case_%0d: lookups=%0d drop=%0d, required lookups=%0d drop=%0d", k, n_lookups, drop_count, lk0, exp_drop);
      else n_pass++;
    end
  endtask

  // Valid header, lookup miss: frame consumed, nothing emitted
  task automatic test_lookup_miss();
    int st;
    build_frame(MY_PORT, 120);
    expect_frame(1'b0, 10'h0);
    send_frame(st);
    exp_drop++;
    wait_drain("lookup_miss");
    check_counts("lookup_miss");
  endtask

  // 4-beat frame with downstream ready toggling every cycle
  task automatic test_backpressure();
    int st;
    bp_mode = 1'b1;
    build_frame(MY_PORT, 188);
    expect_frame(1'b1, 10'h2A);
    send_frame(st);
    exp_pkt++;
    wait_drain("backpressure");
    bp_mode = 1'b0;
    check_counts("backpressure");
  endtask

  // Consecutive frames covering the flush path and header-only frames
  task automatic test_back_to_back();
    int st;
    int plens[4] = '{72, 22, 0, 64};
    for (int k = 0; k < 4; k++) begin
      build_frame(MY_PORT, plens[k]);
      expect_frame(1'b1, 10'(k + 1));
      send_frame(st);
      exp_pkt++;
    end
    wait_drain("back_to_back");
    check_counts("back_to_back");
  endtask

  // Reset on beat 2 of a 4-beat frame, then a clean frame
  task automatic test_reset_midframe();
    int st;
    build_frame(MY_PORT, 188);
    expect_frame(1'b1, 10'h7);
    st = 0;
    send_beat(0, st);
    send_beat(1, st);
    @(posedge clk); #1;
    cmac_tdata[7:0] = 8'hEE;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmac_tready !== 1'b0) $display("FAIL midreset_tready: %0b, required 0", cmac_tready);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    exp_q.delete();
    lk_q.delete();
    exp_pkt = 0;
    exp_drop = 0;
    n_checks++;
    if (udp_tvalid !== 1'b0 || m00_valid !== 1'b0 || pkt_count !== 32'd0 || drop_count !== 32'd0)
      $display("FAIL midreset_idle: tvalid=%0b lkv=%0b pkt=%0d drop=%0d, required 0 0 0 0", udp_tvalid, m00_valid, pkt_count, drop_count);
    else n_pass++;
    @(posedge clk); #1;
    cmac_tvalid = 1'b0;
    cmac_tlast  = 1'b0;
    rst = 1'b0;
    build_frame(MY_PORT, 100);
    expect_frame(1'b1, 10'h9);
    send_frame(st);
    exp_pkt++;
    wait_drain("after_reset");
    check_counts("after_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    m00_ready = 1'b1;
    cmac_tvalid = 1'b0;
    cmac_tlast = 1'b0;
    cmac_tdata = '0;
    cmac_tkeep = '0;
    test_reset();
    test_full_beat();
    test_partial_beat();
    test_port_mismatch();
    test_filters();
    test_lookup_miss();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
